// File: rtl/fixed_act_lut_writer.sv
// Runtime loader for an activation LUT: accepts DEPTH entries from a valid/ready stream and writes them to the LUT RAM.
// Optional trailing checksum beat enabled by defining FIXED_ACT_LUT_WRITER_CHECKSUM_EN.
module fixed_act_lut_writer #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_OUT_0_PRECISION_0 = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic                              lut_wr_en,
    output logic [DATA_OUT_0_PRECISION_0-1:0] lut_wr_addr,
    output logic [DATA_IN_0_PRECISION_0-1:0]  lut_wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              lut_valid,
    output logic                              chk_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef FIXED_ACT_LUT_WRITER_CHECKSUM_EN
        S_CHECK = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_e;

    state_e                            state_q;
    logic [DATA_OUT_0_PRECISION_0-1:0] addr_q;
    logic [DATA_OUT_0_PRECISION_0-1:0] addr_d;
    logic                              wr_en_q;
    logic [DATA_OUT_0_PRECISION_0-1:0] wr_addr_q;
    logic [DATA_IN_0_PRECISION_0-1:0]  wr_data_q;
    logic                              done_q;
    logic                              lut_valid_q;
    logic                              chk_err_q;

    assign addr_d = addr_q + {{(DATA_OUT_0_PRECISION_0-1){1'b0}}, 1'b1};

`ifdef FIXED_ACT_LUT_WRITER_CHECKSUM_EN
    localparam int CW = (DATA_IN_0_PRECISION_0 < 16) ? DATA_IN_0_PRECISION_0 : 16;
    logic [15:0] sum_q;
    logic [15:0] sum_d;
    logic        mismatch;

    assign sum_d    = sum_q + 16'(data_in_0);
    assign mismatch = (data_in_0[CW-1:0] != sum_q[CW-1:0]);
    assign busy            = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    assign busy            = (state_q == S_LOAD);
`endif
    // Ready is a pure state decode so the source never sees a valid-dependent ready.
    assign data_in_0_ready = busy;
    assign lut_wr_en       = wr_en_q;
    assign lut_wr_addr     = wr_addr_q;
    assign lut_wr_data     = wr_data_q;
    assign done            = done_q;
    assign lut_valid       = lut_valid_q;
    assign chk_err         = chk_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            lut_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
`ifdef FIXED_ACT_LUT_WRITER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        addr_q      <= '0;
                        lut_valid_q <= 1'b0;
                        chk_err_q   <= 1'b0;
`ifdef FIXED_ACT_LUT_WRITER_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (data_in_0_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= data_in_0;
                        addr_q    <= addr_d;
`ifdef FIXED_ACT_LUT_WRITER_CHECKSUM_EN
                        sum_q     <= sum_d;
                        if (addr_q == '1) begin
                            state_q <= S_CHECK;
                        end
`else
                        // The counter wraps to 0 on this beat, which is also the exit from LOAD.
                        if (addr_q == '1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef FIXED_ACT_LUT_WRITER_CHECKSUM_EN
                S_CHECK: begin
                    if (data_in_0_valid) begin
                        chk_err_q <= mismatch;
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    lut_valid_q <= ~chk_err_q;
                    state_q     <= S_IDLE;
                end
`else
                S_DONE: begin
                    lut_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_act_lut_writer.sv
// Directed self-checking bench for fixed_act_lut_writer (default 8-bit entries, 256-entry table).
module tb_fixed_act_lut_writer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_in_0;
    logic       data_in_0_valid;
    logic       data_in_0_ready;
    logic       lut_wr_en;
    logic [7:0] lut_wr_addr;
    logic [7:0] lut_wr_data;
    logic       busy;
    logic       done;
    logic       lut_valid;
    logic       chk_err;

    int checks;
    int passed;

    fixed_act_lut_writer #(
        .DATA_IN_0_PRECISION_0 (8),
        .DATA_OUT_0_PRECISION_0(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .data_in_0      (data_in_0),
        .data_in_0_valid(data_in_0_valid),
        .data_in_0_ready(data_in_0_ready),
        .lut_wr_en      (lut_wr_en),
        .lut_wr_addr    (lut_wr_addr),
        .lut_wr_data    (lut_wr_data),
        .busy           (busy),
        .done           (done),
        .lut_valid      (lut_valid),
        .chk_err        (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #12;
        checks++;
        if ({data_in_0_ready, lut_wr_en, lut_wr_addr, lut_wr_data, busy, done, lut_valid, chk_err} !== 22'd0)
            $display("FAIL reset_outputs got rdy=%b en=%b a=%h d=%h busy=%b done=%b lv=%b err=%b want all 0",
                     data_in_0_ready, lut_wr_en, lut_wr_addr, lut_wr_data, busy, done, lut_valid, chk_err);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_idle();
        data_in_0_valid = 1'b1;
        data_in_0       = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (data_in_0_ready !== 1'b0 || lut_wr_en !== 1'b0 || lut_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL idle_no_start got rdy=%b en=%b lv=%b busy=%b want 0 0 0 0",
                         data_in_0_ready, lut_wr_en, lut_valid, busy);
            else passed++;
        end
        data_in_0_valid = 1'b0;
    endtask

    // mode 0: valid held high; mode 1: valid pattern 1,0,0,1 repeating.
    // ign_cyc: load cycle in which a (to be ignored) start pulse is driven; -1 for none.
    task automatic do_load(input int mode, input int nbeats, input int ign_cyc, input logic lv_before);
        int         idx;
        int         cyc;
        int         writes;
        int         pidx;
        logic [7:0] pdata;
        logic       hs_prev;
        logic       v;
        logic       exp_done;
        logic       fin;
        idx = 0; cyc = 0; writes = 0; pidx = 0; pdata = '0; hs_prev = 1'b0; fin = 1'b0;
        @(negedge clk);
        checks++;
        if (lut_valid !== lv_before) $display("FAIL lut_valid_before_start got %b want %b", lut_valid, lv_before);
        else passed++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            checks++;
            if (lut_wr_en !== hs_prev) $display("FAIL wr_en cyc=%0d got %b want %b", cyc, lut_wr_en, hs_prev);
            else passed++;
            if (hs_prev) begin
                writes++;
                checks++;
                if (lut_wr_addr !== 8'(pidx) || lut_wr_data !== pdata)
                    $display("FAIL wr_beat got a=%h d=%h want a=%h d=%h", lut_wr_addr, lut_wr_data, 8'(pidx), pdata);
                else passed++;
            end else if (writes > 0) begin
                checks++;
                if (lut_wr_addr !== 8'(pidx) || lut_wr_data !== pdata)
                    $display("FAIL wr_hold got a=%h d=%h want a=%h d=%h", lut_wr_addr, lut_wr_data, 8'(pidx), pdata);
                else passed++;
            end
            exp_done = hs_prev && (pidx == 255);
            checks++;
            if (done !== exp_done) $display("FAIL done_pulse cyc=%0d got %b want %b", cyc, done, exp_done);
            else passed++;
            if (exp_done) begin
                fin = 1'b1;
            end else begin
                checks++;
                if (data_in_0_ready !== 1'b1 || busy !== 1'b1 || lut_valid !== 1'b0)
                    $display("FAIL load_status cyc=%0d got rdy=%b busy=%b lv=%b want 1 1 0",
                             cyc, data_in_0_ready, busy, lut_valid);
                else passed++;
                if (idx >= nbeats && !hs_prev) begin
                    fin = 1'b1;
                end else begin
                    v = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
                    if (idx >= nbeats) v = 1'b0;
                    start           = (cyc == ign_cyc);
                    data_in_0_valid = v;
                    data_in_0       = 8'(idx) ^ 8'hA5;
                    hs_prev         = v;
                    if (v) begin
                        pidx  = idx;
                        pdata = 8'(idx) ^ 8'hA5;
                        idx++;
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        data_in_0_valid = 1'b0;
        start           = 1'b0;
        checks++;
        if (!fin) $display("FAIL load_timeout got %0d cycles want completion", cyc);
        else passed++;
        if (nbeats == 256) begin
            checks++;
            if (writes != 256) $display("FAIL write_count got %0d want 256", writes);
            else passed++;
            @(negedge clk);
            checks++;
            if (lut_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || lut_wr_en !== 1'b0 || data_in_0_ready !== 1'b0)
                $display("FAIL after_done got lv=%b done=%b busy=%b en=%b rdy=%b want 1 0 0 0 0",
                         lut_valid, done, busy, lut_wr_en, data_in_0_ready);
            else passed++;
        end
    endtask

    task automatic test_full_load();
        do_load(0, 256, -1, 1'b0);
    endtask

    task automatic test_throttled();
        do_load(1, 256, -1, 1'b1);
    endtask

    task automatic test_reload_ignored_start();
        do_load(0, 256, 60, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        do_load(0, 100, -1, 1'b1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({data_in_0_ready, lut_wr_en, lut_wr_addr, lut_wr_data, busy, done, lut_valid, chk_err} !== 22'd0)
            $display("FAIL midload_reset got rdy=%b en=%b a=%h d=%h busy=%b lv=%b want all 0",
                     data_in_0_ready, lut_wr_en, lut_wr_addr, lut_wr_data, busy, lut_valid);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        do_load(0, 256, -1, 1'b0);
    endtask

`ifdef FIXED_ACT_LUT_WRITER_CHECKSUM_EN
    task automatic test_checksum(input logic [7:0] cs, input logic exp_err);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            data_in_0       = 8'h01;
            data_in_0_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (data_in_0_ready !== 1'b1 || busy !== 1'b1 || lut_wr_en !== 1'b1 || lut_wr_addr !== 8'hFF || done !== 1'b0)
            $display("FAIL check_state got rdy=%b busy=%b en=%b a=%h done=%b want 1 1 1 ff 0",
                     data_in_0_ready, busy, lut_wr_en, lut_wr_addr, done);
        else passed++;
        data_in_0 = cs;
        @(negedge clk);
        data_in_0_valid = 1'b0;
        checks++;
        if (lut_wr_en !== 1'b0 || done !== 1'b1 || chk_err !== exp_err || busy !== 1'b0)
            $display("FAIL check_done got en=%b done=%b err=%b busy=%b want 0 1 %b 0",
                     lut_wr_en, done, chk_err, busy, exp_err);
        else passed++;
        @(negedge clk);
        checks++;
        if (lut_valid !== ~exp_err || chk_err !== exp_err || done !== 1'b0 || lut_wr_en !== 1'b0)
            $display("FAIL check_result got lv=%b err=%b done=%b en=%b want %b %b 0 0",
                     lut_valid, chk_err, done, lut_wr_en, ~exp_err, exp_err);
        else passed++;
    endtask
`endif

    initial begin
        checks          = 0;
        passed          = 0;
        rst             = 1'b0;
        start           = 1'b0;
        data_in_0       = '0;
        data_in_0_valid = 1'b0;
        test_reset();
        test_idle();
`ifdef FIXED_ACT_LUT_WRITER_CHECKSUM_EN
        test_checksum(8'h00, 1'b0);
        test_checksum(8'h01, 1'b1);
`else
        test_full_load();
        test_throttled();
        test_reload_ignored_start();
        test_reset_mid_load();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fixed_act_lut_writer.md
Name: fixed_act_lut_writer

Overview:
- Loads an activation lookup table (e.g. SiLU or GELU maps) at runtime from a valid/ready stream, so tables no longer come from a fixed $readmemb file.
- Drives a synchronous write port into the LUT RAM that the fixed_* activation blocks read.
- Raises lut_valid once every entry has been written, so the activation datapath can gate its own traffic on it.

Parameters:
- DATA_IN_0_PRECISION_0, 8, LUT entry width in bits (the activation output width).
- DATA_OUT_0_PRECISION_0, 8, LUT address width in bits; DEPTH = 2**DATA_OUT_0_PRECISION_0.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a load; honoured only in IDLE.
- data_in_0, input, DATA_IN_0_PRECISION_0, table entry stream, address 0 first.
- data_in_0_valid, input, 1, entry valid.
- data_in_0_ready, output, 1, entry accepted when valid and ready are both 1.
- lut_wr_en, output, 1, write strobe to the LUT RAM.
- lut_wr_addr, output, DATA_OUT_0_PRECISION_0, write address.
- lut_wr_data, output, DATA_IN_0_PRECISION_0, write data.
- busy, output, 1, high while a load is in progress.
- done, output, 1, one-cycle pulse when a load completes.
- lut_valid, output, 1, table is complete and readable.
- chk_err, output, 1, checksum mismatch (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; addr counter=0; the following outputs are 0: data_in_0_ready, lut_wr_en, lut_wr_addr, lut_wr_data, busy, done, lut_valid, chk_err. Reset asserted mid-load discards the partial load, and lut_valid stays 0.
- States:
  - IDLE: start=1 -> LOAD; clear addr to 0; clear lut_valid and chk_err.
  - LOAD: data_in_0_ready=1, decoded from state only (no dependence on valid). Each handshake writes the entry and increments addr. The handshake at addr==DEPTH-1 -> CHECK if the macro is defined, else -> DONE.
  - CHECK (macro only): ready=1; accepts exactly one beat, then -> DONE.
  - DONE: lasts exactly one cycle; done=1; lut_valid set to 1; -> IDLE.
- busy = (state is LOAD or CHECK).
- start is ignored outside IDLE.
- start arriving while lut_valid=1 begins a reload; lut_valid drops to 0 on the cycle after start.
- Write port, latency 1: a handshake in cycle N gives lut_wr_en=1 in cycle N+1, with lut_wr_addr = that beat's index and lut_wr_data = that beat's data.
- lut_wr_en is 0 in every cycle not preceded by a handshake. lut_wr_addr and lut_wr_data hold their last values while lut_wr_en=0.
- Back-to-back handshakes give back-to-back writes with no bubbles. valid gaps (valid=0) produce no writes and do not advance addr.
- Address counter is DATA_OUT_0_PRECISION_0 bits and wraps naturally from DEPTH-1 to 0. The wrap coincides with leaving LOAD, so no write past DEPTH-1 is ever issued.
- Ordering at completion: the last write (cycle N+1) occurs in the same cycle as the done pulse; lut_valid=1 from cycle N+2.
- Without the macro, chk_err is tied to 0.

Optional Feature:
- Macro: FIXED_ACT_LUT_WRITER_CHECKSUM_EN.
- Defined:
  - A 16-bit accumulator, cleared on start, adds each entry (zero-extended) modulo 2^16 on every LOAD handshake.
  - In CHECK, the single accepted beat holds the expected checksum in its low min(16, DATA_IN_0_PRECISION_0) bits. This beat is not written to the LUT.
  - Mismatch: chk_err=1, set in the DONE cycle and held until the next start or reset; lut_valid stays 0.
  - Match: lut_valid=1 as normal.
- Undefined: no CHECK state; loading ends after DEPTH beats; chk_err=0.

Test Plan:
- Reset then idle: data_in_0_valid=1 held with no start -> ready=0, no lut_wr_en, lut_valid=0.
- Full load, default params: start, then 256 beats with data=addr^0xA5 and valid held high -> 256 consecutive writes at addr 0..255 with matching data; done pulse on the last write; lut_valid=1 the next cycle.
- Throttled source: valid pattern 1,0,0,1 repeating -> writes only one cycle after each handshake; addr sequence unbroken; total writes 256.
- Reset mid-load: assert rst after 100 beats -> all outputs 0 immediately; a later start reloads from addr 0; lut_valid is asserted only after 256 new beats.
- Reload and ignored start: start pulsed during LOAD has no effect; start after completion drops lut_valid the next cycle and the load repeats.
- With FIXED_ACT_LUT_WRITER_CHECKSUM_EN, 8-bit entries all 0x01: trailing beat 0x00 (matching low byte of 0x0100) -> lut_valid=1, chk_err=0; trailing beat 0x01 -> chk_err=1, lut_valid=0, and no write to addr 0 from the trailing beat.
